// File: rtl/bcd_timer_n_if.sv
// Control/status bundle of the BCD timer.
//   master : drives loadn, data, start, stop, en, up; observes count and flags
//   slave  : the timer itself
// Ports:
//   loadn    active-low synchronous load
//   data     load value, digit i in bits [4i+3:4i]
//   start    level request for RUN
//   stop     level request for PAUSED
//   en       count tick from the prescaler
//   up       direction, 1 = up, 0 = down
//   count    registered counter value
//   zero     count == 0
//   tc       terminal count reached on a live tick
//   running  state is RUN
//   done     state is DONE, or a one-cycle reload pulse with autoreload
interface bcd_timer_n_if #(
    parameter int DIGITS = 2
);
    logic                  loadn;
    logic [4*DIGITS-1:0]   data;
    logic                  start;
    logic                  stop;
    logic                  en;
    logic                  up;
    logic [4*DIGITS-1:0]   count;
    logic                  zero;
    logic                  tc;
    logic                  running;
    logic                  done;

    modport master (
        output loadn, data, start, stop, en, up,
        input  count, zero, tc, running, done
    );

    modport slave (
        input  loadn, data, start, stop, en, up,
        output count, zero, tc, running, done
    );
endinterface

// File: rtl/bcd_timer_n.sv
// Multi-digit BCD timer built from cascaded modulo-MOD digits, with load,
// up/down counting, start/stop/pause control and terminal-count handling.
// Build option: define TIMER_AUTORELOAD_EN to reload the last loaded value
// at terminal count and keep running, pulsing done for one cycle.
// Ports:
//   clk    clock, all state changes on the rising edge
//   clear  synchronous active-high reset, highest priority
//   bus    bcd_timer_n_if.slave control/status bundle
//
// state  | meaning
// IDLE   | cleared or freshly loaded, waiting for start
// RUN    | counting on every en tick
// PAUSED | stopped by stop, count held, start resumes
// DONE   | terminal count reached, held until load or clear
module bcd_timer_n #(
    parameter int DIGITS = 2,
    parameter int MOD    = 10
) (
    input  logic         clk,
    input  logic         clear,
    bcd_timer_n_if.slave bus
);
    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] MAXD = 4'(MOD - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t         state;
    logic [W-1:0]   cnt;
    logic [W-1:0]   cnt_step;
    logic [W-1:0]   cnt_load;
    logic           at_term;
    logic           running_q;
    logic           done_q;
    logic [3:0]     dig;
    logic           carry;
    logic [3:0]     ldig;

    // Ripple the carry/borrow through the digits; a digit moves only when
    // every lower digit is about to wrap. A carry out of the top digit means
    // the whole count sits at its terminal value.
    always_comb begin
        cnt_step = cnt;
        carry    = 1'b1;
        dig      = '0;
        for (int i = 0; i < DIGITS; i++) begin
            dig = cnt[4*i +: 4];
            if (carry) begin
                if (bus.up)
                    cnt_step[4*i +: 4] = (dig == MAXD) ? 4'd0 : dig + 4'd1;
                else
                    cnt_step[4*i +: 4] = (dig == 4'd0) ? MAXD : dig - 4'd1;
            end
            carry = carry & (bus.up ? (dig == MAXD) : (dig == 4'd0));
        end
        at_term = carry;
    end

    // Out-of-range load digits saturate to MOD-1.
    always_comb begin
        cnt_load = '0;
        ldig     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            ldig = bus.data[4*i +: 4];
            cnt_load[4*i +: 4] = (ldig > MAXD) ? MAXD : ldig;
        end
    end

`ifdef TIMER_AUTORELOAD_EN
    logic [W-1:0] reload;

    always_ff @(posedge clk) begin
        if (clear)
            reload <= '0;
        else if (!bus.loadn)
            reload <= cnt_load;
    end
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= IDLE;
            cnt       <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else if (!bus.loadn) begin
            state     <= IDLE;
            cnt       <= cnt_load;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE, PAUSED: begin
                    if (bus.start && !bus.stop) begin
                        state     <= RUN;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (bus.stop) begin
                        state     <= PAUSED;
                        running_q <= 1'b0;
                    end else if (bus.en) begin
                        if (at_term) begin
`ifdef TIMER_AUTORELOAD_EN
                            cnt    <= reload;
                            done_q <= 1'b1;
`else
                            state     <= DONE;
                            running_q <= 1'b0;
                            done_q    <= 1'b1;
`endif
                        end else begin
                            cnt <= cnt_step;
                        end
                    end
                end
                DONE: begin
                    done_q <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count   = cnt;
    assign bus.zero    = (cnt == '0);
    assign bus.tc      = running_q & bus.en & at_term;
    assign bus.running = running_q;
    assign bus.done    = done_q;
endmodule

// File: doc/bcd_timer_n.md
Name: bcd_timer_n

Overview:
Parametrised multi-digit BCD timer built from cascaded per-digit modulo counters. It supports load, up or down counting, start/stop/pause control and a terminal-count/done indication. It sits between the prescaler tick source and the display/decoder logic. It replaces hand-chained single-digit mod-10 counters in the timer level.

Parameters:
DIGITS, 2, number of cascaded digits (1..8); digit 0 is least significant.
MOD, 10, modulus of every digit (2..16); digit range 0..MOD-1.

Ports:
clk  in  1  clock; all state changes on posedge clk.
clear  in  1  synchronous reset, active-high; highest priority.
loadn  in  1  synchronous load, active-low.
data  in  4*DIGITS  load value; digit i is bits [4i+3:4i].
start  in  1  level; requests RUN.
stop  in  1  level; requests PAUSED.
en  in  1  count tick enable from prescaler, active-high.
up  in  1  direction: 1 = up, 0 = down.
count  out  4*DIGITS  registered counter value.
zero  out  1  comb: count == 0.
tc  out  1  comb: running & en & count at terminal (down: all 0; up: all digits MOD-1).
running  out  1  registered: state == RUN.
done  out  1  registered: state == DONE (pulse when autoreload is enabled).

Behaviour:
- FSM states: IDLE, RUN, PAUSED, DONE.
- Priority per cycle: clear > loadn low > stop > start > counting.
- clear: count=0 and state=IDLE. After the edge, running=0, done=0, zero=1, tc=0.
- loadn low: each digit loads min(data digit, MOD-1), so out-of-range digits saturate. State goes to IDLE and the reload register captures the saturated value.
- IDLE/PAUSED + start (stop low) -> RUN on the next edge. Counting begins on the cycle after entering RUN; start itself does not tick.
- RUN + stop -> PAUSED, and count holds on that edge. When start and stop are both high, stop wins.
- DONE: start is ignored. Only loadn or clear leaves DONE.
- RUN with en=1, down mode:
  - Digit 0 decrements.
  - Digit i>0 changes only when all lower digits are 0. It then decrements, or wraps 0 -> MOD-1.
- RUN with en=1, up mode:
  - Digit 0 increments.
  - Digit i>0 changes only when all lower digits are MOD-1. It then increments, or wraps MOD-1 -> 0.
- en=0: count holds and the state is unchanged.
- Terminal handling: when RUN, en=1 and count is at terminal (tc=1), count does not change, state -> DONE and done=1 from the next cycle. Example: down from 1 gives 1 -> 0 (tick), then DONE on the following tick. Entering RUN with count already 0 in down mode therefore reaches DONE on the first en tick.
- up may change at any time. It takes effect on the next tick and is evaluated combinationally per cycle.
- Latency: count updates one cycle after a qualifying en. The zero and tc outputs follow count combinationally.
- clear or loadn mid-RUN aborts counting immediately, with no extra tick.

Optional Feature:
TIMER_AUTORELOAD_EN.
- Defined: at terminal in RUN with en=1, count loads the reload register, the state stays RUN, and done pulses high for exactly one cycle. DONE is unreachable.
- Undefined: terminal -> DONE, holding as described above. The reload register is not synthesised.

Test Plan:
1. DIGITS=2, MOD=10: loadn with data=0x12, start, en=1 continuously -> count 0x11, 0x10, 0x09 (borrow, digit1 1->0, digit0 0->9), ..., 0x00. On the next tick done=1, running=0, and count holds at 0x00.
2. Up mode from 0x97 -> 0x98, 0x99. Next tick: tc=1 on the 0x99 cycle, DONE, count holds at 0x99.
3. Load data=0xFC with MOD=10 -> count=0x99 (both digits saturated). Load 0x3A -> 0x39.
4. RUN at 0x05, assert start and stop together -> PAUSED, count stays 0x05 over 3 en ticks. Deassert stop with start high -> RUN, and the next tick gives 0x04.
5. clear asserted mid-RUN with loadn low the same cycle -> count=0x00, IDLE. clear wins. done=0, zero=1.
6. With TIMER_AUTORELOAD_EN: load 0x02, run -> 0x01, 0x00, then reload to 0x02 with a single-cycle done pulse, running stays 1, and counting continues to 0x01.
